// File: rtl/alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Multi-cycle AVR-style ALU. Single-cycle arithmetic, logic and
//               shift operations complete on the accept edge. MUL, MULS and
//               MULSU run an iterative shift-add multiplier (one partial
//               product per clock) and report a 2W-bit product.
//
// Ports       : clk        rising-edge clock
//               reset      synchronous, active-high; clears all state/outputs
//               start      request, accepted only while busy=0
//               op[3:0]    operation code (0 NOP .. 14 MULSU, 15 = NOP)
//               rd, rr     W-bit operands (rd = destination operand)
//               flags_in   SREG in, bit order C Z N V S H T I (bit 0..7)
//               busy       multiply in progress
//               done       one-cycle pulse, results valid
//               out_lo     result / low half of product
//               out_hi     high half of product, 0 for non-multiplies
//               flags_out  updated SREG
//
// Revision    : 1.0  initial release
// ============================================================================
module alu_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] rr,
  input  logic [7:0]            flags_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] out_lo,
  output logic [DATA_WIDTH-1:0] out_hi,
  output logic [7:0]            flags_out
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_ADC   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_SBC   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_EOR   = 4'd7;
  localparam logic [3:0] OP_NEG   = 4'd8;
  localparam logic [3:0] OP_LSR   = 4'd9;
  localparam logic [3:0] OP_ASR   = 4'd10;
  localparam logic [3:0] OP_ROR   = 4'd11;
  localparam logic [3:0] OP_MUL   = 4'd12;
  localparam logic [3:0] OP_MULS  = 4'd13;
  localparam logic [3:0] OP_MULSU = 4'd14;

  localparam logic [CW-1:0] CNT_LAST = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_WIDTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t state;

  // --------------------------------------------------------------------------
  // Single-cycle datapath (evaluated on the inputs present at the accept edge)
  // --------------------------------------------------------------------------
  logic          cin;
  logic          cin_add;
  logic          cin_sub;
  logic [W:0]    sum_ext;
  logic [W:0]    diff_ext;
  logic [4:0]    sum_nib;
  logic [4:0]    diff_nib;
  logic [W-1:0]  neg_res;
  logic          shift_msb;

  assign cin     = flags_in[0];
  assign cin_add = (op == OP_ADC) & cin;
  assign cin_sub = (op == OP_SBC) & cin;

  // Carries and borrows are taken one bit above the operand width.
  assign sum_ext  = {1'b0, rd} + {1'b0, rr} + {{W{1'b0}}, cin_add};
  assign diff_ext = {1'b0, rd} - {1'b0, rr} - {{W{1'b0}}, cin_sub};

  // Nibble-wide copies give the half-carry / half-borrow at bit 4.
  assign sum_nib  = {1'b0, rd[3:0]} + {1'b0, rr[3:0]} + {4'b0000, cin_add};
  assign diff_nib = {1'b0, rd[3:0]} - {1'b0, rr[3:0]} - {4'b0000, cin_sub};

  assign neg_res  = {W{1'b0}} - rd;

  // Bit shifted into the MSB for LSR / ASR / ROR.
  always_comb begin
    shift_msb = 1'b0;
    if (op == OP_ASR) begin
      shift_msb = rd[W-1];
    end else if (op == OP_ROR) begin
      shift_msb = cin;
    end
  end

  logic [W-1:0] alu_res;
  logic [7:0]   alu_flags;
  logic         f_c;
  logic         f_z;
  logic         f_n;
  logic         f_v;
  logic         f_s;
  logic         f_h;

  always_comb begin
    // Defaults pass every flag through unchanged (NOP behaviour).
    alu_res = '0;
    f_c     = flags_in[0];
    f_z     = flags_in[1];
    f_n     = flags_in[2];
    f_v     = flags_in[3];
    f_s     = flags_in[4];
    f_h     = flags_in[5];

    case (op)
      OP_ADD, OP_ADC: begin
        alu_res = sum_ext[W-1:0];
        f_c     = sum_ext[W];
        f_h     = sum_nib[4];
        // Overflow: operands agree in sign, result does not.
        f_v     = (rd[W-1] == rr[W-1]) && (alu_res[W-1] != rd[W-1]);
        f_n     = alu_res[W-1];
        f_s     = f_n ^ f_v;
        f_z     = (alu_res == '0);
      end

      OP_SUB, OP_SBC: begin
        alu_res = diff_ext[W-1:0];
        f_c     = diff_ext[W];
        f_h     = diff_nib[4];
        // Overflow: operands differ in sign and result sign differs from rd.
        f_v     = (rd[W-1] != rr[W-1]) && (alu_res[W-1] != rd[W-1]);
        f_n     = alu_res[W-1];
        f_s     = f_n ^ f_v;
        // SBC keeps Z sticky so multi-word compares chain correctly.
        if (op == OP_SBC) begin
          f_z = flags_in[1] & (alu_res == '0);
        end else begin
          f_z = (alu_res == '0);
        end
      end

      OP_AND, OP_OR, OP_EOR: begin
        if (op == OP_AND) begin
          alu_res = rd & rr;
        end else if (op == OP_OR) begin
          alu_res = rd | rr;
        end else begin
          alu_res = rd ^ rr;
        end
        f_v = 1'b0;
        f_n = alu_res[W-1];
        f_s = f_n;
        f_z = (alu_res == '0);
      end

      OP_NEG: begin
        alu_res = neg_res;
        f_c     = (neg_res != '0);
        f_v     = (neg_res == {1'b1, {(W-1){1'b0}}});
        f_h     = neg_res[3] | ~rd[3];
        f_n     = neg_res[W-1];
        f_s     = f_n ^ f_v;
        f_z     = (neg_res == '0);
      end

      OP_LSR, OP_ASR, OP_ROR: begin
        alu_res = {shift_msb, rd[W-1:1]};
        f_c     = rd[0];
        f_n     = alu_res[W-1];
        f_v     = f_n ^ f_c;
        f_s     = f_n ^ f_v;
        f_z     = (alu_res == '0);
      end

      default: begin
        alu_res = '0;
      end
    endcase

    alu_flags = {flags_in[7:6], f_h, f_s, f_v, f_n, f_z, f_c};
  end

  logic is_mul;
  logic rd_signed_req;

  assign is_mul        = (op == OP_MUL) || (op == OP_MULS) || (op == OP_MULSU);
  assign rd_signed_req = (op == OP_MULS) || (op == OP_MULSU);

  // --------------------------------------------------------------------------
  // Iterative shift-add multiplier
  // --------------------------------------------------------------------------
  // The multiplicand is held at 2W bits (sign- or zero-extended) and shifted
  // left each step; the multiplier is consumed LSB first. For a signed rr the
  // MSB carries weight -2^(W-1), so the final partial product is subtracted
  // instead of added. All arithmetic is modulo 2^(2W), which is exact here.
  logic [PW-1:0] mcand;
  logic [W-1:0]  mplier;
  logic [PW-1:0] acc;
  logic [PW-1:0] acc_next;
  logic [CW-1:0] count;
  logic          rr_signed;
  logic [7:0]    mul_flags;

  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      if (rr_signed && (count == CNT_LAST)) begin
        acc_next = acc - mcand;
      end else begin
        acc_next = acc + mcand;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_lo    <= '0;
      out_hi    <= '0;
      flags_out <= '0;
      count     <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      rr_signed <= 1'b0;
      mul_flags <= '0;
    end else begin
      done <= 1'b0;

      if (state == ST_IDLE) begin
        if (start) begin
          if (is_mul) begin
            state     <= ST_MUL;
            busy      <= 1'b1;
            count     <= CNT_LOAD;
            mcand     <= rd_signed_req ? {{W{rd[W-1]}}, rd} : {{W{1'b0}}, rd};
            mplier    <= rr;
            acc       <= '0;
            rr_signed <= (op == OP_MULS);
            mul_flags <= flags_in;
          end else begin
            out_lo    <= alu_res;
            out_hi    <= '0;
            flags_out <= alu_flags;
            done      <= 1'b1;
          end
        end
      end else begin
        acc    <= acc_next;
        mcand  <= {mcand[PW-2:0], 1'b0};
        mplier <= {1'b0, mplier[W-1:1]};
        count  <= count - CNT_LAST;

        if (count == CNT_LAST) begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          done      <= 1'b1;
          out_lo    <= acc_next[W-1:0];
          out_hi    <= acc_next[PW-1:W];
          // Multiplies only touch C (product sign bit) and Z.
          flags_out <= {mul_flags[7:2], (acc_next == '0), acc_next[PW-1]};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq. Drives a W=8 and a W=16
//               instance and compares against an arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start8;
  logic [3:0]  op8;
  logic [7:0]  rd8, rr8, fin8;
  logic        busy8, done8;
  logic [7:0]  lo8, hi8, fo8;

  logic        start16;
  logic [3:0]  op16;
  logic [15:0] rd16, rr16;
  logic [7:0]  fin16;
  logic        busy16, done16;
  logic [15:0] lo16, hi16;
  logic [7:0]  fo16;

  alu_seq #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .rd(rd8), .rr(rr8),
    .flags_in(fin8), .busy(busy8), .done(done8), .out_lo(lo8), .out_hi(hi8),
    .flags_out(fo8)
  );

  alu_seq #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .rd(rd16), .rr(rr16),
    .flags_in(fin16), .busy(busy16), .done(done16), .out_lo(lo16), .out_hi(hi16),
    .flags_out(fo16)
  );

  int checks   = 0;
  int failures = 0;

  function automatic longint rnd(input longint mask);
    return longint'($urandom) & mask;
  endfunction

  // Reference model: results computed directly from the arithmetic rules.
  task automatic model(input int w, input int op, input longint a, input longint b,
                       input longint fin, output longint lo, output longint hi,
                       output longint fo);
    longint mask, half, sa, sb, r, ss, p, k, cin, c, z, n, v, s, h;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sa   = (a >= half) ? a - mask - 1 : a;
    sb   = (b >= half) ? b - mask - 1 : b;
    cin  = fin & 1;
    c = cin; z = (fin >> 1) & 1; n = (fin >> 2) & 1;
    v = (fin >> 3) & 1; s = (fin >> 4) & 1; h = (fin >> 5) & 1;
    lo = 0; hi = 0; k = 0;
    case (op)
      1, 2: begin
        k  = (op == 2) ? cin : 0;
        r  = a + b + k;
        lo = r & mask;
        c  = longint'(r > mask);
        h  = longint'(((a & 15) + (b & 15) + k) > 15);
        ss = sa + sb + k;
        v  = longint'(ss >= half || ss < -half);
      end
      3, 4: begin
        k  = (op == 4) ? cin : 0;
        r  = a - b - k;
        lo = r & mask;
        c  = longint'(r < 0);
        h  = longint'(((a & 15) - (b & 15) - k) < 0);
        ss = sa - sb - k;
        v  = longint'(ss >= half || ss < -half);
      end
      5: begin lo = a & b; v = 0; end
      6: begin lo = a | b; v = 0; end
      7: begin lo = a ^ b; v = 0; end
      8: begin
        lo = (0 - a) & mask;
        c  = longint'(lo != 0);
        v  = longint'(lo == half);
        h  = ((lo >> 3) & 1) | (((a >> 3) & 1) ^ 1);
      end
      9:  lo = a >> 1;
      10: lo = (a >> 1) | (a & half);
      11: lo = (a >> 1) | ((cin != 0) ? half : 0);
      12, 13, 14: begin
        p  = (op == 12) ? a * b : (op == 13) ? sa * sb : sa * b;
        p  = p & ((longint'(1) << (2 * w)) - 1);
        lo = p & mask;
        hi = p >> w;
        c  = (p >> (2 * w - 1)) & 1;
        z  = longint'(p == 0);
      end
      default: ;
    endcase
    if (op >= 1 && op <= 11) begin
      n = longint'(lo >= half);
      if (op >= 9) begin
        c = a & 1;
        v = n ^ c;
      end
      z = (op == 4) ? (z & longint'(lo == 0)) : longint'(lo == 0);
      s = n ^ v;
    end
    fo = (fin & 'hC0) | (h << 5) | (s << 4) | (v << 3) | (n << 2) | (z << 1) | c;
  endtask

  task automatic drive(input int w, input bit st, input int op, input longint a,
                       input longint b, input longint fin);
    if (w == 8) begin
      start8 = st; op8 = op[3:0]; rd8 = a[7:0]; rr8 = b[7:0]; fin8 = fin[7:0];
    end else begin
      start16 = st; op16 = op[3:0]; rd16 = a[15:0]; rr16 = b[15:0]; fin16 = fin[7:0];
    end
  endtask

  task automatic sample(input int w, output bit bsy, output bit dn, output longint lo,
                        output longint hi, output longint fo);
    if (w == 8) begin
      bsy = busy8; dn = done8;
      lo = longint'(lo8); hi = longint'(hi8); fo = longint'(fo8);
    end else begin
      bsy = busy16; dn = done16;
      lo = longint'(lo16); hi = longint'(hi16); fo = longint'(fo16);
    end
  endtask

  // Issues one op and waits (bounded) for done. edges counts edges from the
  // accept edge inclusive; busy_cycles counts sampled cycles with busy=1.
  task automatic run_op(input int w, input int op, input longint a, input longint b,
                        input longint fin, input bit scramble, output int edges,
                        output int busy_cycles, output longint lo, output longint hi,
                        output longint fo);
    bit bsy, dn;
    @(negedge clk);
    drive(w, 1'b1, op, a, b, fin);
    @(posedge clk); #1;
    if (scramble) drive(w, 1'b0, int'($urandom_range(15)), rnd('hFFFF), rnd('hFFFF), rnd('hFF));
    else          drive(w, 1'b0, op, a, b, fin);
    edges = 1;
    busy_cycles = 0;
    sample(w, bsy, dn, lo, hi, fo);
    while (!dn && edges < 64) begin
      if (bsy) busy_cycles++;
      @(posedge clk); #1;
      if (scramble) drive(w, 1'b0, int'($urandom_range(15)), rnd('hFFFF), rnd('hFFFF), rnd('hFF));
      edges++;
      sample(w, bsy, dn, lo, hi, fo);
    end
    if (bsy) busy_cycles++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(8, 1'b0, 0, 0, 0, 0);
    drive(16, 1'b0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy8, done8, hi8, lo8, fo8} !== 26'd0) begin
      failures++;
      $display("FAIL reset8: got busy=%b done=%b hi=%h lo=%h f=%h, want all 0",
               busy8, done8, hi8, lo8, fo8);
    end
    checks++;
    if ({busy16, done16, hi16, lo16, fo16} !== 42'd0) begin
      failures++;
      $display("FAIL reset16: got busy=%b done=%b hi=%h lo=%h f=%h, want all 0",
               busy16, done16, hi16, lo16, fo16);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed8();
    int e, bc;
    longint lo, hi, fo;
    // ADD 0x7F + 0x01
    run_op(8, 1, 'h7F, 'h01, 'h00, 1'b0, e, bc, lo, hi, fo);
    checks++;
    if (e != 1 || lo !== 'h80 || hi !== 0 || fo !== 'h2C) begin
      failures++;
      $display("FAIL add_7f_01: got edges=%0d lo=%h hi=%h f=%h, want 1 80 00 2c", e, lo, hi, fo);
    end
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0 || lo8 !== 8'h80 || fo8 !== 8'h2C) begin
      failures++;
      $display("FAIL done_single_pulse: got done=%b lo=%h f=%h, want 0 80 2c", done8, lo8, fo8);
    end
    // SBC 0x00 - 0x00 - C
    run_op(8, 4, 'h00, 'h00, 'h03, 1'b0, e, bc, lo, hi, fo);
    checks++;
    if (e != 1 || lo !== 'hFF || hi !== 0 || fo !== 'h35) begin
      failures++;
      $display("FAIL sbc_borrow: got edges=%0d lo=%h hi=%h f=%h, want 1 ff 00 35", e, lo, hi, fo);
    end
    // MUL 0xFF * 0xFF
    run_op(8, 12, 'hFF, 'hFF, 'h00, 1'b0, e, bc, lo, hi, fo);
    checks++;
    if (e != 9 || bc != 8 || hi !== 'hFE || lo !== 'h01 || fo !== 'h01) begin
      failures++;
      $display("FAIL mul_ff_ff: got edges=%0d busy=%0d p=%h%h f=%h, want 9 8 fe01 01",
               e, bc, hi, lo, fo);
    end
    // MULS 0x80 * 0x80
    run_op(8, 13, 'h80, 'h80, 'h00, 1'b0, e, bc, lo, hi, fo);
    checks++;
    if (e != 9 || hi !== 'h40 || lo !== 'h00 || fo !== 'h00) begin
      failures++;
      $display("FAIL muls_80_80: got edges=%0d p=%h%h f=%h, want 9 4000 00", e, hi, lo, fo);
    end
    // MULSU 0xFF * 0x02
    run_op(8, 14, 'hFF, 'h02, 'h00, 1'b0, e, bc, lo, hi, fo);
    checks++;
    if (e != 9 || hi !== 'hFF || lo !== 'hFE || fo !== 'h01) begin
      failures++;
      $display("FAIL mulsu_ff_02: got edges=%0d p=%h%h f=%h, want 9 fffe 01", e, hi, lo, fo);
    end
  endtask

  task automatic test_random_single();
    int e, bc, o;
    longint a, b, f, lo, hi, fo, elo, ehi, efo;
    for (int i = 0; i < 80; i++) begin
      o = int'($urandom_range(12));
      if (o == 12) o = 15;
      a = rnd('hFF); b = rnd('hFF); f = rnd('hFF);
      model(8, o, a, b, f, elo, ehi, efo);
      run_op(8, o, a, b, f, 1'b0, e, bc, lo, hi, fo);
      checks++;
      if (e != 1 || bc != 0 || lo !== elo || hi !== ehi || fo !== efo) begin
        failures++;
        $display("FAIL rand_single op=%0d rd=%h rr=%h fin=%h: got e=%0d lo=%h hi=%h f=%h, want 1 %h %h %h",
                 o, a, b, f, e, lo, hi, fo, elo, ehi, efo);
      end
    end
  endtask

  task automatic test_random_mul();
    int e, bc, o;
    longint a, b, f, lo, hi, fo, elo, ehi, efo;
    for (int i = 0; i < 24; i++) begin
      o = 12 + int'($urandom_range(2));
      a = rnd('hFF); b = rnd('hFF); f = rnd('hFF);
      if (i == 0) a = 0;
      model(8, o, a, b, f, elo, ehi, efo);
      run_op(8, o, a, b, f, 1'b1, e, bc, lo, hi, fo);
      checks++;
      if (e != 9 || bc != 8 || lo !== elo || hi !== ehi || fo !== efo) begin
        failures++;
        $display("FAIL rand_mul op=%0d rd=%h rr=%h fin=%h: got e=%0d b=%0d p=%h%h f=%h, want 9 8 %h%h %h",
                 o, a, b, f, e, bc, hi, lo, fo, ehi, elo, efo);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int e, extra;
    longint elo, ehi, efo;
    model(8, 12, 'h9D, 'h37, 'h00, elo, ehi, efo);
    @(negedge clk);
    drive(8, 1'b1, 12, 'h9D, 'h37, 'h00);
    @(posedge clk); #1;
    drive(8, 1'b0, 12, 'h9D, 'h37, 'h00);
    e = 1;
    repeat (2) begin @(posedge clk); #1; e++; end
    drive(8, 1'b1, 1, 'h11, 'h22, 'h00);   // ADD during busy cycle 3
    @(posedge clk); #1; e++;
    drive(8, 1'b0, 1, 'h11, 'h22, 'h00);
    while (!done8 && e < 64) begin @(posedge clk); #1; e++; end
    checks++;
    if (e != 9 || lo8 !== elo[7:0] || hi8 !== ehi[7:0] || fo8 !== efo[7:0]) begin
      failures++;
      $display("FAIL busy_ignore: got e=%0d p=%h%h f=%h, want 9 %h%h %h",
               e, hi8, lo8, fo8, ehi, elo, efo);
    end
    extra = 0;
    repeat (12) begin @(posedge clk); #1; if (done8) extra++; end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL busy_ignore_extra_done: got %0d pulses, want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int e, bc, o;
    longint a, b, f, lo, hi, fo, elo, ehi, efo;
    run_op(8, 13, 'h7F, 'h81, 'h00, 1'b0, e, bc, lo, hi, fo);
    // Now in the done cycle: ADD issued here must complete one edge later.
    model(8, 1, 'h12, 'h34, 'h00, elo, ehi, efo);
    run_op(8, 1, 'h12, 'h34, 'h00, 1'b0, e, bc, lo, hi, fo);
    checks++;
    if (e != 1 || lo !== elo || hi !== ehi || fo !== efo) begin
      failures++;
      $display("FAIL add_in_done_cycle: got e=%0d lo=%h f=%h, want 1 %h %h", e, lo, fo, elo, efo);
    end
    // start held high: one single-cycle result per clock.
    for (int i = 0; i < 12; i++) begin
      o = 1 + int'($urandom_range(10));
      a = rnd('hFF); b = rnd('hFF); f = rnd('hFF);
      model(8, o, a, b, f, elo, ehi, efo);
      @(negedge clk);
      drive(8, 1'b1, o, a, b, f);
      @(posedge clk); #1;
      checks++;
      if (done8 !== 1'b1 || lo8 !== elo[7:0] || hi8 !== ehi[7:0] || fo8 !== efo[7:0]) begin
        failures++;
        $display("FAIL b2b op=%0d rd=%h rr=%h fin=%h: got done=%b lo=%h f=%h, want 1 %h %h",
                 o, a, b, f, done8, lo8, fo8, elo, efo);
      end
    end
    @(negedge clk);
    drive(8, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_mul();
    int e, bc, extra;
    longint lo, hi, fo;
    @(negedge clk);
    drive(8, 1'b1, 12, 'hFF, 'hFF, 'hC0);
    @(posedge clk); #1;
    drive(8, 1'b0, 12, 'hFF, 'hFF, 'hC0);
    repeat (3) begin @(posedge clk); #1; end   // now in busy cycle 4
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy8, done8, hi8, lo8, fo8} !== 26'd0) begin
      failures++;
      $display("FAIL reset_mid_mul: got busy=%b done=%b hi=%h lo=%h f=%h, want all 0",
               busy8, done8, hi8, lo8, fo8);
    end
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    repeat (12) begin @(posedge clk); #1; if (done8 || busy8) extra++; end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL reset_abort_no_done: got %0d active cycles, want 0", extra);
    end
    run_op(8, 1, 'h01, 'h01, 'h00, 1'b0, e, bc, lo, hi, fo);
    checks++;
    if (e != 1 || lo !== 'h02 || hi !== 0 || fo !== 'h00) begin
      failures++;
      $display("FAIL add_after_reset: got e=%0d lo=%h f=%h, want 1 02 00", e, lo, fo);
    end
  endtask

  task automatic test_w16();
    int e, bc, o;
    longint a, b, f, lo, hi, fo, elo, ehi, efo;
    run_op(16, 12, 'hFFFF, 'h0002, 'h00, 1'b0, e, bc, lo, hi, fo);
    checks++;
    if (e != 17 || bc != 16 || hi !== 'h0001 || lo !== 'hFFFE || fo !== 'h00) begin
      failures++;
      $display("FAIL mul16_ffff_2: got e=%0d busy=%0d p=%h_%h f=%h, want 17 16 0001_fffe 00",
               e, bc, hi, lo, fo);
    end
    run_op(16, 11, 'h0001, 'h0000, 'h01, 1'b0, e, bc, lo, hi, fo);
    checks++;
    if (e != 1 || lo !== 'h8000 || hi !== 0 || fo !== 'h15) begin
      failures++;
      $display("FAIL ror16: got e=%0d lo=%h f=%h, want 1 8000 15", e, lo, fo);
    end
    for (int i = 0; i < 24; i++) begin
      o = int'($urandom_range(14));
      a = rnd('hFFFF); b = rnd('hFFFF); f = rnd('hFF);
      model(16, o, a, b, f, elo, ehi, efo);
      run_op(16, o, a, b, f, 1'b1, e, bc, lo, hi, fo);
      checks++;
      if (e != ((o >= 12) ? 17 : 1) || lo !== elo || hi !== ehi || fo !== efo) begin
        failures++;
        $display("FAIL rand16 op=%0d rd=%h rr=%h fin=%h: got e=%0d p=%h_%h f=%h, want %h_%h %h",
                 o, a, b, f, e, hi, lo, fo, ehi, elo, efo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed8();
    test_random_single();
    test_random_mul();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_mul();
    test_w16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
